// File: rtl/riscv_pkg.sv
// Shared definitions for the 3-stage pipeline: fetch FSM states, the
// canonical NOP encoding and the base-ISA major opcodes used by decode.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps exactly one imem read in flight and
// fills the registered IF/DE slot consumed directly by decode.
//
// state | meaning
// ISSUE | send a request for pc_q (suppressed on a redirect)
// WAIT  | request for pc_q in flight; a response may chain the next request
// HOLD  | response parked in buf_q because decode is stalled on a full slot
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  import riscv_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         kill_q, kill_d;
  logic         req;
  logic [31:0]  addr;
  logic         load;
  logic [31:0]  load_instr;
  logic [31:0]  target;
  logic [31:0]  pc_inc;

  assign target    = redirect_pc & ~32'h0000_0003;
  assign pc_inc    = pc_q + 32'd4;
  // Reset forces the request low even though the FSM already sits in ISSUE.
  assign imem_req  = req & ~rst;
  assign imem_addr = addr & ~32'h0000_0003;

  // Next-state, PC/kill/buffer updates and request generation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    buf_d      = buf_q;
    req        = 1'b0;
    addr       = pc_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    case (state_q)
      ISSUE: begin
        if (redirect_valid) begin
          pc_d = target;
        end else begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!imem_rvalid) begin
          // Redirect with the read still in flight: its response is stale.
          if (redirect_valid) begin
            kill_d = 1'b1;
            pc_d   = target;
          end
        end else if (redirect_valid) begin
          pc_d    = target;
          kill_d  = 1'b0;
          state_d = ISSUE;
        end else if (kill_q) begin
          kill_d  = 1'b0;
          state_d = ISSUE;
        end else if (!stall || !if_valid) begin
          load = 1'b1;
          pc_d = pc_inc;
          req  = 1'b1;
          addr = pc_inc;
        end else begin
          buf_d   = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = ISSUE;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = buf_q;
          pc_d       = pc_inc;
          req        = 1'b1;
          addr       = pc_inc;
          state_d    = WAIT;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // FSM, PC, kill flag and hold buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC & ~32'h0000_0003;
      kill_q  <= 1'b0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      buf_q   <= buf_d;
    end
  end

  // IF/DE slot: redirect flush beats load, load beats stall-hold, else bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= pc_q;
      if_instr <= load_instr;
    end else if (!(stall && if_valid)) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a simple one-outstanding memory model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int failures = 0;

  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0040_0293 : (a ^ 32'hA5A5_0013);
  endfunction

  // Memory: capture the request mid-cycle, answer lat cycles later.
  always @(negedge clk) begin
    if (!rst && imem_req) begin
      paddr = imem_addr;
      cnt   = lat;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (rst) cnt = 0;
    else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(paddr);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    checks++; if (if_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_instr, NOP); end
    do_reset();
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL first_slot_empty got=%b exp=0", if_valid); end
    next_cycle(); @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL second_req got=%b/%h exp=1/4", imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0040_0293}) begin failures++; $display("FAIL first_slot got=%b/%h/%h exp=1/0/00400293", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      next_cycle(); @(negedge clk);
      checks++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * i), mem(32'(4 * i))}) begin
        failures++; $display("FAIL b2b_slot%0d got=%b/%h/%h exp=1/%h/%h", i, if_valid, if_pc, if_instr, 32'(4 * i), mem(32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    next_cycle();
    next_cycle(); stall = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req_c%0d got=%b exp=0", c, imem_req); end
      checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0040_0293}) begin failures++; $display("FAIL stall_hold_c%0d got=%b/%h/%h exp=1/0/00400293", c, if_valid, if_pc, if_instr); end
      if (c < 5) next_cycle();
    end
    next_cycle(); stall = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin failures++; $display("FAIL stall_release_req got=%b/%h exp=1/8", imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, mem(32'h4)}) begin failures++; $display("FAIL stall_buffered got=%b/%h/%h exp=1/4/%h", if_valid, if_pc, if_instr, mem(32'h4)); end
  endtask

  task automatic test_redirect_wait();
    do_reset(); lat = 3;
    @(negedge clk);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdw_redirect_req got=%b exp=0", imem_req); end
    next_cycle(); redirect_valid = 1'b0; lat = 1;
    next_cycle(); @(negedge clk);
    checks++; if ({imem_req, if_valid} !== 2'b00) begin failures++; $display("FAIL rdw_drop got=req%b/valid%b exp=0/0", imem_req, if_valid); end
    next_cycle(); @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL rdw_target_req got=%b/%h exp=1/100", imem_req, imem_addr); end
    checks++; if ({if_valid, if_instr} !== {1'b0, NOP}) begin failures++; $display("FAIL rdw_bubble got=%b/%h exp=0/%h", if_valid, if_instr, NOP); end
    next_cycle(); next_cycle(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, mem(32'h100)}) begin failures++; $display("FAIL rdw_slot got=%b/%h/%h exp=1/100/%h", if_valid, if_pc, if_instr, mem(32'h100)); end
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset();
    next_cycle();
    next_cycle(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rrs_req got=%b exp=0", imem_req); end
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL rrs_target_req got=%b/%h exp=1/200", imem_req, imem_addr); end
    checks++; if ({if_valid, if_instr} !== {1'b0, NOP}) begin failures++; $display("FAIL rrs_flush got=%b/%h exp=0/%h", if_valid, if_instr, NOP); end
    next_cycle(); @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h204}) begin failures++; $display("FAIL rrs_load_req got=%b/%h exp=1/204", imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, mem(32'h200)}) begin failures++; $display("FAIL rrs_slot got=%b/%h/%h exp=1/200/%h", if_valid, if_pc, if_instr, mem(32'h200)); end
    stall = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_redirect_req got=%b exp=0", imem_req); end
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL mis_addr got=%b/%h exp=1/200", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wrap_req1 got=%b/%h exp=1/0", imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC)}) begin failures++; $display("FAIL wrap_slot0 got=%b/%h/%h exp=1/fffffffc/%h", if_valid, if_pc, if_instr, mem(32'hFFFF_FFFC)); end
    next_cycle(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0040_0293}) begin failures++; $display("FAIL wrap_slot1 got=%b/%h/%h exp=1/0/00400293", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_misaligned();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 3-stage pipeline; sits directly upstream of instruction decode. Owns the PC, issues one-outstanding-request reads to instruction memory, and presents `{valid, pc, instr}` in a registered IF/DE slot. Honours the decode stall and redirects from execute (branch/jal/jalr), discarding wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): value driven on `if_instr` whenever the slot is empty.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request strobe; one cycle per request.
- `imem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `imem_rvalid`  in  1  response valid; one pulse per request, latency ≥1 cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `stall`  in  1  decode cannot accept; hold the IF/DE slot.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  target; bits [1:0] ignored (treated as 0).
- `if_valid`  out  1  slot holds a real instruction.
- `if_pc`  out  32  PC of the instruction in the slot.
- `if_instr`  out  32  instruction word; `NOP_INSTR` when `if_valid`=0.

## Operation
- Registers: `state`, `pc_q` (address of the outstanding or next request), `kill_q`, `buf_q` (32-bit hold buffer), output slot.
- States: ISSUE, WAIT, HOLD.
- ISSUE: `imem_req`=!`redirect_valid`, `imem_addr`=`pc_q`. With redirect: `pc_q`←target, stay in ISSUE. Otherwise go to WAIT.
- WAIT without `imem_rvalid`: a redirect sets `kill_q`←1 and `pc_q`←target.
- WAIT with `imem_rvalid`, first matching case wins:
  - Redirect: drop the response, `pc_q`←target, `kill_q`←0, go to ISSUE.
  - `kill_q`: drop the response, `kill_q`←0, go to ISSUE.
  - Slot free (!`stall` or !`if_valid`): load the slot with {1, `pc_q`, rdata}. `pc_q`←`pc_q`+4. Same cycle `imem_req`=1, `imem_addr`=`pc_q`+4. Stay in WAIT.
  - Otherwise: `buf_q`←rdata, go to HOLD.
- HOLD: a redirect discards `buf_q`, sets `pc_q`←target, goes to ISSUE. Else on !`stall`: load the slot with {1, `pc_q`, `buf_q`}, `pc_q`←`pc_q`+4, issue `pc_q`+4 the same cycle, go to WAIT.
- Slot update priority:
  1. Redirect: `if_valid`←0, `if_instr`←`NOP_INSTR`.
  2. Load (as above).
  3. `stall` with a valid slot: hold.
  4. Else: bubble (`if_valid`←0, `NOP_INSTR`).
- Redirect always beats stall. The redirect cycle never issues a request.
- Arithmetic: PC +4 is modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset values: `state`=ISSUE, `pc_q`=`RESET_PC`, `kill_q`=0, `buf_q`=0, `if_valid`=0, `if_pc`=0, `if_instr`=`NOP_INSTR`. `imem_req`=0 while `rst`=1.
- First request is in the first cycle after `rst` falls.
- With 1-cycle memory latency and no stall, throughput is 1 instruction/cycle. Response in cycle n means `if_valid` in cycle n+1.
- Reset mid-request: the outstanding response is ignored; memory must drop it, because no kill tracking survives reset.
- Exactly one request is outstanding at any time. `imem_rvalid` while in ISSUE or HOLD is a protocol error.

## Structure
- Shared `riscv_pkg`: `NOP_INSTR` constant, `fetch_state_e` enum {ISSUE, WAIT, HOLD}, and the opcode localparams, moved there from decode.
- No sub-module. The slot register stays in this block, and decode consumes it directly.

## Test plan
- Reset release, 1-cycle memory returning 32'h00400293 at address 0: `imem_req`/`imem_addr`=0 in cycle 1. Slot is {1, 0, 32'h00400293} in cycle 3. Addr 4 is requested in cycle 2.
- `stall` held 3 cycles while a response arrives: enter HOLD, slot unchanged. After release, the buffered word appears with PC+4, and no request is issued during the stall.
- Redirect to 32'h0000_0100 while in WAIT, response 2 cycles later: the response is dropped, `if_valid`=0. The next request is to 0x100 and the slot shows PC 0x100.
- Redirect and `imem_rvalid` in the same cycle, with `stall`=1: the response is dropped and the slot is flushed to NOP. The next request is to the target.
- `redirect_pc`=32'h0000_0203: `imem_addr`=32'h0000_0200.
- Redirect to 32'hFFFF_FFFC, two responses: slot PCs are FFFF_FFFC then 0000_0000.
